// File: rtl/fibonacci_pkg.sv
// Shared Fibonacci definitions: the checker state type and the two seed terms.
package fibonacci_pkg;

    typedef enum logic [1:0] {
        SEED0,
        SEED1,
        TRACK,
        HALT
    } fib_state_e;

    localparam int FIB_SEED0 = 1;
    localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fibonacci_next.sv
// Next Fibonacci term: plain mod-2^W sum of the two most recent terms.
module fibonacci_next #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    // Carry out is dropped so the sequence wraps around.
    always_comb begin
        sum = a + b;
    end

endmodule

// File: rtl/fibonacci_checker.sv
// Fibonacci sequence checker: compares each accepted term against the next
// expected term and reports ok/err pulses plus a saturating run length.
// Build option: FIB_CHECK_STOP_ON_ERR_EN -- stop in HALT on the first
// mismatch until reset (default: resync to SEED0).
module fibonacci_checker
    import fibonacci_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             ok,
    output logic             err,
    output logic [W-1:0]     expected,
    output logic [CNT_W-1:0] run_len
);

    fib_state_e state;
    logic [W-1:0] last;
    logic [W-1:0] next_term;
    logic         xfer;
    logic         match;

    fibonacci_next #(.W(W)) u_next (
        .a   (in_data),
        .b   (last),
        .sum (next_term)
    );

    // Handshake and comparison; in_ready depends on the state register only.
    always_comb begin
        in_ready = (state != HALT);
        xfer     = in_valid && in_ready;
        match    = (in_data == expected);
    end

    // Checker FSM with registered ok/err/expected/run_len.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEED0;
            ok       <= 1'b0;
            err      <= 1'b0;
            expected <= W'(FIB_SEED0);
            run_len  <= '0;
            last     <= '0;
        end else begin
            ok  <= 1'b0;
            err <= 1'b0;
            if (xfer) begin
                if (match) begin
                    ok      <= 1'b1;
                    last    <= in_data;
                    run_len <= (run_len == '1) ? run_len : run_len + CNT_W'(1);
                    case (state)
                        SEED0: begin
                            state    <= SEED1;
                            expected <= W'(FIB_SEED1);
                        end
                        SEED1, TRACK: begin
                            state    <= TRACK;
                            expected <= next_term;
                        end
                        default: begin
                            state <= state;
                        end
                    endcase
                end else begin
                    err <= 1'b1;
`ifdef FIB_CHECK_STOP_ON_ERR_EN
                    state <= HALT;
`else
                    // The offending term is dropped even if it equals 1; the
                    // next accepted term is checked as a fresh SEED0.
                    state    <= SEED0;
                    expected <= W'(FIB_SEED0);
                    run_len  <= '0;
                    last     <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Self-checking bench for fibonacci_checker (W=16, CNT_W=8).
// Honours FIB_CHECK_STOP_ON_ERR_EN the same way as the design.
module tb_fibonacci_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        ok;
    logic        err;
    logic [15:0] expected;
    logic [7:0]  run_len;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: terms accepted since the last sync, halt flag, run count.
    logic [15:0] hist[$];
    bit          m_halt;
    int unsigned m_run;

    always #5 clk = ~clk;

    fibonacci_checker #(.W(16), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ok       (ok),
        .err      (err),
        .expected (expected),
        .run_len  (run_len)
    );

    function automatic logic [15:0] model_exp();
        logic [15:0] s;
        if (hist.size() < 2) begin
            s = 16'd1;
        end else begin
            s = hist[hist.size()-1] + hist[hist.size()-2];
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input bit exp_ok, input bit exp_err);
        check({tag, ".ok"}, 32'(ok), 32'(exp_ok));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".expected"}, 32'(expected), 32'(model_exp()));
        check({tag, ".run_len"}, 32'(run_len), m_run);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_halt));
    endtask

    task automatic xfer(input logic [15:0] d);
        bit rdy;
        bit match;
        rdy      = !m_halt;
        match    = (d == model_exp());
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom();
        if (rdy) begin
            if (match) begin
                hist.push_back(d);
                if (m_run < 255) m_run++;
            end else begin
`ifdef FIB_CHECK_STOP_ON_ERR_EN
                m_halt = 1'b1;
`else
                hist.delete();
                m_run = 0;
`endif
            end
        end
        check_state("xfer", rdy && match, rdy && !match);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_state("idle", 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        hist.delete();
        m_run  = 0;
        m_halt = 1'b0;
        check_state("reset", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_state("reset_hold", 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        m_halt   = 1'b0;
        m_run    = 0;
        @(posedge clk);
        #1;
        check_state("por", 1'b0, 1'b0);
        check("por.expected_is_1", 32'(expected), 32'd1);
        rst = 1'b0;

        // Back-to-back 1,1,2,3,5,8
        xfer(16'd1); xfer(16'd1); xfer(16'd2);
        xfer(16'd3); xfer(16'd5); xfer(16'd8);
        check("b2b.run_len", 32'(run_len), 32'd6);
        check("b2b.expected", 32'(expected), 32'd13);

        // Run up to 28657, then cross the 16-bit wrap
        for (int i = 0; i < 40 && hist[hist.size()-1] != 16'd28657; i++) begin
            xfer(model_exp());
        end
        check("wrap.last_is_28657", 32'(expected), 32'd46368);
        xfer(16'd46368);
        check("wrap.ok_46368", 32'(ok), 32'd1);
        xfer(16'd9489);
        check("wrap.ok_9489", 32'(ok), 32'd1);
        check("wrap.expected", 32'(expected), 32'd55857);

        // Mismatch after 1,1,2
        do_reset();
        xfer(16'd1); xfer(16'd1); xfer(16'd2); xfer(16'd4);
        check("mis.err", 32'(err), 32'd1);
`ifdef FIB_CHECK_STOP_ON_ERR_EN
        check("halt.in_ready", 32'(in_ready), 32'd0);
        check("halt.run_len", 32'(run_len), 32'd3);
        xfer(16'd3);
        xfer(16'd1);
        check("halt.ignored_ok", 32'(ok), 32'd0);
        check("halt.run_held", 32'(run_len), 32'd3);
        do_reset();
        xfer(16'd1); xfer(16'd1); xfer(16'd5);
        check("halt2.err", 32'(err), 32'd1);
        idle(1);
        check("halt2.in_ready", 32'(in_ready), 32'd0);
        xfer(16'd2);
        check("halt2.run_len", 32'(run_len), 32'd2);
        do_reset();
        check("halt2.ready_after_rst", 32'(in_ready), 32'd1);
`else
        check("mis.run_len", 32'(run_len), 32'd0);
        check("mis.expected", 32'(expected), 32'd1);
        xfer(16'd1); xfer(16'd1); xfer(16'd2);
        check("resync.run_len", 32'(run_len), 32'd3);
        // A mismatching 1 is not taken as SEED0
        xfer(16'd1);
        check("mis1.err", 32'(err), 32'd1);
        xfer(16'd1);
        check("mis1.run_len", 32'(run_len), 32'd1);
        check("mis1.expected", 32'(expected), 32'd1);
`endif

        // Valid gaps of 0..3 idle cycles
        do_reset();
        xfer(16'd1); idle(3);
        xfer(16'd1); idle(0);
        xfer(16'd2); idle(2);
        xfer(16'd3); idle(1);
        check("gap.run_len", 32'(run_len), 32'd4);
        check("gap.expected", 32'(expected), 32'd5);

        // Reset mid-run, then 3 then 1
        do_reset();
        xfer(16'd1); xfer(16'd1); xfer(16'd2);
        do_reset();
        xfer(16'd3);
        check("rstmid.err", 32'(err), 32'd1);
        xfer(16'd1);
`ifndef FIB_CHECK_STOP_ON_ERR_EN
        check("rstmid.ok", 32'(ok), 32'd1);
`endif

        // Run-length saturation
        do_reset();
        for (int i = 0; i < 260; i++) xfer(model_exp());
        check("sat.run_len", 32'(run_len), 32'd255);
        xfer(model_exp());
        check("sat.run_len_hold", 32'(run_len), 32'd255);

        // Randomised mix of good terms, bad terms, gaps and resets
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                do_reset();
            end else if (r < 3) begin
                xfer(16'($urandom()));
            end else if (r == 3) begin
                xfer(16'd1);
            end else begin
                xfer(model_exp());
            end
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ok and err are exclusive in every cycle
    always @(negedge clk) begin
        if (ok && err) begin
            n_cmp++;
            n_err++;
            $error("FAIL ok_err_exclusive observed=11 expected=not both");
        end
    end

endmodule

// File: doc/fibonacci_checker.md
FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

Interface
REQ-001 Parameter W, default 16: data width of each sequence term.
REQ-002 Parameter CNT_W, default 8: width of the run-length counter.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  in_data carries a term this cycle.
REQ-006 in_data  input  W  incoming term.
REQ-007 in_ready  output  1  checker accepts a term this cycle; a transfer occurs when in_valid && in_ready.
REQ-008 ok  output  1  registered pulse: the term accepted in the previous cycle matched.
REQ-009 err  output  1  registered pulse: the term accepted in the previous cycle mismatched.
REQ-010 expected  output  W  registered value the next accepted term must equal.
REQ-011 run_len  output  CNT_W  consecutive matching terms since the last (re)sync, saturating.

Function
REQ-012 The FSM SHALL have the states SEED0, SEED1, TRACK and HALT.
REQ-013 SEED0: expected = 1; match -> SEED1.
REQ-014 SEED1: expected = 1; match -> TRACK.
REQ-015 TRACK: expected = (t[n-1] + t[n-2]) mod 2^W, with wrap-around and no saturation; match -> stay in TRACK.
REQ-016 Any mismatch in SEED0, SEED1 or TRACK SHALL discard the term, set run_len to 0, set expected to 1 and go to SEED0 (resync).
REQ-017 A mismatching term equal to 1 SHALL NOT be counted as a new SEED0 term.
REQ-018 Latency: ok, err, expected and run_len SHALL reflect an accepted term exactly one cycle after the transfer.
REQ-019 Without a transfer, ok and err SHALL be 0 and all state SHALL hold.
REQ-020 ok and err SHALL never be high in the same cycle.
REQ-021 On a match, run_len SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-022 in_ready SHALL be 1 in every state except HALT, where it SHALL be 0.
REQ-023 in_ready SHALL be a function of state only, with no combinational path from in_valid.
REQ-024 Gaps in in_valid SHALL NOT affect checking.

Reset
REQ-025 While rst is high: state = SEED0, ok = 0, err = 0, expected = 1, run_len = 0, in_ready = 1, internal term history = 0.
REQ-026 A reset asserted mid-sequence SHALL abandon the sequence.
REQ-027 The first transfer after reset is released SHALL be checked against 1.

Configuration
REQ-028 The macro FIB_CHECK_STOP_ON_ERR_EN SHALL select the mismatch behaviour.
REQ-029 With FIB_CHECK_STOP_ON_ERR_EN defined, a mismatch SHALL pulse err, go to HALT and hold expected and run_len; HALT SHALL be left only by rst.
REQ-030 With FIB_CHECK_STOP_ON_ERR_EN undefined, HALT SHALL be unreachable and a mismatch SHALL resync per REQ-016.

Structure
REQ-031 Package fibonacci_pkg SHALL hold the state enum type and the constants FIB_SEED0 = 1 and FIB_SEED1 = 1, shared with the fibonacci generators.
REQ-032 One sub-module, fibonacci_next, SHALL be used: a combinational mod-2^W adder computing the next expected term.

Verification
REQ-033 Continuous valid with terms 1,1,2,3,5,8 -> six ok pulses, run_len = 6, then expected = 13.
REQ-034 Wrap-around: after terms up to 17711, 28657, send 46368 then 9489 -> both give ok, then expected = 55857.
REQ-035 Resync (macro off): terms 1,1,2,4 -> err one cycle after 4, run_len = 0, expected = 1; then 1,1,2 -> three ok pulses.
REQ-036 Valid gaps: terms 1,1,2,3 sent with 0-3 idle cycles between them -> same ok pulses and run_len = 4 as the back-to-back case.
REQ-037 Reset mid-run: rst pulsed after 1,1,2, then 3 sent -> err; then 1 sent -> ok.
REQ-038 Macro on: terms 1,1,5 -> err, in_ready = 0 from the next cycle, further valid terms ignored, run_len held at 2; rst restores in_ready = 1.
